// File: rtl/rtc_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rtc_pkg : field codes, field ranges, button FSM encoding, BCD helpers    |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package rtc_pkg;

   localparam logic [3:0] FLD_SEC   = 4'd0;
   localparam logic [3:0] FLD_MIN   = 4'd1;
   localparam logic [3:0] FLD_HOUR  = 4'd2;
   localparam logic [3:0] FLD_DAY   = 4'd3;
   localparam logic [3:0] FLD_YEAR  = 4'd4;
   localparam logic [3:0] FLD_MONTH = 4'd5;

   localparam int SEC_MIN   = 0;
   localparam int SEC_MAX   = 59;
   localparam int MIN_MIN   = 0;
   localparam int MIN_MAX   = 59;
   localparam int HOUR_MIN  = 0;
   localparam int HOUR_MAX  = 23;
   localparam int DAY_MIN   = 1;
   localparam int DAY_MAX   = 31;
   localparam int MONTH_MIN = 1;
   localparam int MONTH_MAX = 12;
   localparam int YEAR_MIN  = 0;
   localparam int YEAR_MAX  = 99;

   localparam logic [1:0] BTN_IDLE   = 2'd0;
   localparam logic [1:0] BTN_FIRST  = 2'd1;
   localparam logic [1:0] BTN_HOLD   = 2'd2;
   localparam logic [1:0] BTN_REPEAT = 2'd3;

   function automatic logic [7:0] bin2bcd99(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   function automatic logic [6:0] bcd2bin(input logic [7:0] b);
      return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_btn_repeat.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rtc_btn_repeat : up/down button edge detect with hold-then-repeat steps  |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module rtc_btn_repeat
   import rtc_pkg::*;
#(
   parameter int HOLD_CYC = 50_000_000,
   parameter int REP_CYC  = 13_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic up,
   input  logic down,
   output logic step_up,
   output logic step_dn
);

   localparam int MAX_CYC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] HOLD_N = CW'(HOLD_CYC);
   localparam logic [CW-1:0] REP_N  = CW'(REP_CYC);
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic [1:0]    state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          dir_up, dir_nx;
   logic          up_low, dn_low;
   logic          both_lock, lock_nx;
   logic          fire;
   logic          both, held, up_edge, dn_edge;

   // up_low/dn_low mean "last sample was low"; cleared by reset so a button
   // already held when reset releases must be released before it counts.
   assign both    = up & down;
   assign held    = dir_up ? up : down;
   assign up_edge = up & up_low & ~down;
   assign dn_edge = down & dn_low & ~up;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= BTN_IDLE;
         cnt       <= '0;
         dir_up    <= 1'b0;
         up_low    <= 1'b0;
         dn_low    <= 1'b0;
         both_lock <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         dir_up    <= dir_nx;
         up_low    <= ~up;
         dn_low    <= ~down;
         both_lock <= lock_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      dir_nx   = dir_up;
      fire     = 1'b0;
      lock_nx  = both_lock;
      if (both)
         lock_nx = 1'b1;
      else if (!up && !down)
         lock_nx = 1'b0;

      if (!enable || both || both_lock) begin
         state_nx = BTN_IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            BTN_IDLE: begin
               if (up_edge || dn_edge) begin
                  state_nx = BTN_FIRST;
                  cnt_nx   = ONE;
                  dir_nx   = up_edge;
                  fire     = 1'b1;
               end
            end
            BTN_FIRST, BTN_HOLD: begin
               if (!held) begin
                  state_nx = BTN_IDLE;
                  cnt_nx   = '0;
               end else if (cnt == HOLD_N) begin
                  state_nx = BTN_REPEAT;
                  cnt_nx   = ONE;
                  fire     = 1'b1;
               end else begin
                  state_nx = BTN_HOLD;
                  cnt_nx   = cnt + ONE;
               end
            end
            BTN_REPEAT: begin
               if (!held) begin
                  state_nx = BTN_IDLE;
                  cnt_nx   = '0;
               end else if (cnt == REP_N) begin
                  cnt_nx = ONE;
                  fire   = 1'b1;
               end else begin
                  cnt_nx = cnt + ONE;
               end
            end
            default: begin
               state_nx = BTN_IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_comb begin
      step_up = fire & dir_nx;
      step_dn = fire & ~dir_nx;
   end

endmodule
`default_nettype wire

// File: rtl/rtc_field_bcd_counter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rtc_field_bcd_counter : ranged two-digit BCD field, edit/tick/load       |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module rtc_field_bcd_counter
   import rtc_pkg::*;
#(
   parameter int FIELD_ID = 4,
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 99,
   parameter int HOLD_CYC = 50_000_000,
   parameter int REP_CYC  = 13_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] contadoresH,
   input  logic       Arriba,
   input  logic       Abajo,
   input  logic       tick_in,
   input  logic       load_en,
   input  logic [7:0] load_bcd,
   output logic [7:0] datos_bcd,
   output logic       carry_out,
   output logic       load_err,
   output logic       editing
);

   localparam logic [3:0] FID  = 4'(FIELD_ID);
   localparam logic [6:0] VMIN = 7'(MIN_VAL);
   localparam logic [6:0] VMAX = 7'(MAX_VAL);
   localparam logic [7:0] SPAN = 8'(MAX_VAL - MIN_VAL);

   logic [6:0] val, val_nx, ld_bin;
   logic       carry_nx, err_nx;
   logic       in_edit, cur_ok, ld_ok;
   logic       step_up, step_dn;

   // Offset compare in 8 bits: values below MIN wrap far above SPAN.
   function automatic logic in_range(input logic [6:0] v);
      return ({1'b0, v} - {1'b0, VMIN}) <= SPAN;
   endfunction

   assign in_edit = (contadoresH == FID);
   assign ld_bin  = bcd2bin(load_bcd);
   assign ld_ok   = (load_bcd[7:4] <= 4'd9) && (load_bcd[3:0] <= 4'd9) && in_range(ld_bin);
   assign cur_ok  = in_range(val);

   rtc_btn_repeat #(
      .HOLD_CYC (HOLD_CYC),
      .REP_CYC  (REP_CYC)
   ) u_btn (
      .clk     (clk),
      .reset   (reset),
      .enable  (in_edit),
      .up      (Arriba),
      .down    (Abajo),
      .step_up (step_up),
      .step_dn (step_dn)
   );

   always_comb begin
      val_nx   = val;
      carry_nx = 1'b0;
      err_nx   = 1'b0;
      if (load_en) begin
         if (ld_ok)
            val_nx = ld_bin;
         else
            err_nx = 1'b1;
      end else if (step_up) begin
         val_nx = (!cur_ok || val == VMAX) ? VMIN : val + 7'd1;
      end else if (step_dn) begin
         if (!cur_ok)
            val_nx = VMIN;
         else
            val_nx = (val == VMIN) ? VMAX : val - 7'd1;
      end else if (tick_in && !in_edit) begin
         if (!cur_ok) begin
            val_nx = VMIN;
         end else if (val == VMAX) begin
            val_nx   = VMIN;
            carry_nx = 1'b1;
         end else begin
            val_nx = val + 7'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         val       <= VMIN;
         datos_bcd <= bin2bcd99(VMIN);
         carry_out <= 1'b0;
         load_err  <= 1'b0;
         editing   <= 1'b0;
      end else begin
         val       <= val_nx;
         datos_bcd <= bin2bcd99(val_nx);
         carry_out <= carry_nx;
         load_err  <= err_nx;
         editing   <= in_edit;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rtc_field_bcd_counter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_rtc_field_bcd_counter : directed bench, year (0..99) + month (1..12)  |
// | rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_rtc_field_bcd_counter;

   logic       clk;
   logic       reset;
   logic [3:0] contadoresH;
   logic       Arriba, Abajo;
   logic       tick_y, tick_m, ld_y, ld_m;
   logic [7:0] load_bcd;
   logic [7:0] bcd_y, bcd_m;
   logic       carry_y, carry_m, err_y, err_m, edit_y, edit_m;

   int n_assert = 0;
   int n_fail   = 0;

   rtc_field_bcd_counter #(
      .FIELD_ID (4), .MIN_VAL (0), .MAX_VAL (99), .HOLD_CYC (4), .REP_CYC (2)
   ) dut_year (
      .clk (clk), .reset (reset), .contadoresH (contadoresH),
      .Arriba (Arriba), .Abajo (Abajo), .tick_in (tick_y),
      .load_en (ld_y), .load_bcd (load_bcd),
      .datos_bcd (bcd_y), .carry_out (carry_y), .load_err (err_y), .editing (edit_y)
   );

   rtc_field_bcd_counter #(
      .FIELD_ID (5), .MIN_VAL (1), .MAX_VAL (12), .HOLD_CYC (4), .REP_CYC (2)
   ) dut_month (
      .clk (clk), .reset (reset), .contadoresH (contadoresH),
      .Arriba (Arriba), .Abajo (Abajo), .tick_in (tick_m),
      .load_en (ld_m), .load_bcd (load_bcd),
      .datos_bcd (bcd_m), .carry_out (carry_m), .load_err (err_m), .editing (edit_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; contadoresH = 4'd0; Arriba = 1'b0; Abajo = 1'b0;
      tick_y = 1'b0; tick_m = 1'b0; ld_y = 1'b0; ld_m = 1'b0; load_bcd = 8'h00;
      cyc(2);
      reset = 1'b0;
      chk("rst_year", bcd_y, 8'h00);
      chk("rst_month", bcd_m, 8'h01);
      chk("rst_carry", {7'd0, carry_y}, 8'h00);
      chk("rst_err", {7'd0, err_y}, 8'h00);
      chk("rst_edit", {7'd0, edit_y}, 8'h00);

      // 1: single presses and down-wrap
      contadoresH = 4'd4; cyc(1);
      chk("edit_rise", {7'd0, edit_y}, 8'h01);
      Arriba = 1'b1; cyc(1); chk("up_once", bcd_y, 8'h01);
      Arriba = 1'b0; cyc(1);
      Abajo = 1'b1; cyc(1); chk("dn_first", bcd_y, 8'h00);
      Abajo = 1'b0; cyc(1);
      Abajo = 1'b1; cyc(1); chk("dn_wrap", bcd_y, 8'h99);
      chk("dn_wrap_nocarry", {7'd0, carry_y}, 8'h00);
      Abajo = 1'b0; cyc(1);

      // 2: auto-repeat from 10
      load_bcd = 8'h10; ld_y = 1'b1; cyc(1); ld_y = 1'b0;
      chk("load10", bcd_y, 8'h10);
      Arriba = 1'b1; cyc(1); chk("rep_N", bcd_y, 8'h11);
      cyc(3); chk("rep_N3", bcd_y, 8'h11);
      cyc(1); chk("rep_N4", bcd_y, 8'h12);
      cyc(1); chk("rep_N5", bcd_y, 8'h12);
      cyc(1); chk("rep_N6", bcd_y, 8'h13);
      cyc(1); chk("rep_N7", bcd_y, 8'h13);
      cyc(1); chk("rep_N8", bcd_y, 8'h14);
      Arriba = 1'b0; cyc(3); chk("release", bcd_y, 8'h14);
      Arriba = 1'b1; Abajo = 1'b1; cyc(6); chk("both_high", bcd_y, 8'h14);
      Arriba = 1'b0; Abajo = 1'b0; cyc(1);

      // 3: month tick wrap with carry, edit-mode down wrap
      load_bcd = 8'h12; ld_m = 1'b1; cyc(1); ld_m = 1'b0;
      chk("m_load12", bcd_m, 8'h12);
      tick_m = 1'b1; cyc(1); tick_m = 1'b0;
      chk("m_tick_wrap", bcd_m, 8'h01);
      chk("m_carry", {7'd0, carry_m}, 8'h01);
      cyc(1); chk("m_carry_drop", {7'd0, carry_m}, 8'h00);
      contadoresH = 4'd5; Abajo = 1'b1; cyc(1);
      chk("m_dn_wrap", bcd_m, 8'h12);
      chk("y_not_edit", bcd_y, 8'h14);
      chk("m_dn_nocarry", {7'd0, carry_m}, 8'h00);
      Abajo = 1'b0; cyc(1);
      chk("m_editing", {7'd0, edit_m}, 8'h01);

      // 4: load checks
      contadoresH = 4'd0;
      load_bcd = 8'h37; ld_y = 1'b1; cyc(1); ld_y = 1'b0;
      chk("load37", bcd_y, 8'h37);
      chk("load37_err", {7'd0, err_y}, 8'h00);
      load_bcd = 8'h3A; ld_y = 1'b1; cyc(1); ld_y = 1'b0;
      chk("load3A_keep", bcd_y, 8'h37);
      chk("load3A_err", {7'd0, err_y}, 8'h01);
      cyc(1); chk("err_pulse_end", {7'd0, err_y}, 8'h00);
      load_bcd = 8'h13; ld_m = 1'b1; cyc(1); ld_m = 1'b0;
      chk("m_load13_keep", bcd_m, 8'h12);
      chk("m_load13_err", {7'd0, err_m}, 8'h01);
      load_bcd = 8'h42; ld_y = 1'b1; tick_y = 1'b1; cyc(1); ld_y = 1'b0; tick_y = 1'b0;
      chk("load_vs_tick", bcd_y, 8'h42);
      chk("load_vs_tick_carry", {7'd0, carry_y}, 8'h00);
      load_bcd = 8'h99; ld_y = 1'b1; cyc(1); ld_y = 1'b0;
      tick_y = 1'b1; cyc(1); tick_y = 1'b0;
      chk("y_tick_wrap", bcd_y, 8'h00);
      chk("y_carry", {7'd0, carry_y}, 8'h01);
      cyc(1); chk("y_carry_drop", {7'd0, carry_y}, 8'h00);

      // 5: edit freeze and leaving edit mode mid-hold
      contadoresH = 4'd4; tick_y = 1'b1; cyc(3); tick_y = 1'b0;
      chk("freeze", bcd_y, 8'h00);
      chk("freeze_carry", {7'd0, carry_y}, 8'h00);
      Arriba = 1'b1; cyc(1); chk("hold_first", bcd_y, 8'h01);
      cyc(2);
      contadoresH = 4'd2;
      chk("edit_lag", {7'd0, edit_y}, 8'h01);
      cyc(1); chk("edit_fall", {7'd0, edit_y}, 8'h00);
      cyc(5); chk("leave_stops", bcd_y, 8'h01);
      Arriba = 1'b0; cyc(1);

      // 6: reset in REPEAT, held button ignored afterwards
      contadoresH = 4'd4;
      load_bcd = 8'h55; ld_y = 1'b1; cyc(1); ld_y = 1'b0;
      chk("load55", bcd_y, 8'h55);
      Arriba = 1'b1; cyc(1); chk("r_N", bcd_y, 8'h56);
      cyc(3); chk("r_N3", bcd_y, 8'h56);
      cyc(1); chk("r_N4", bcd_y, 8'h57);
      reset = 1'b1; cyc(1);
      chk("mid_reset", bcd_y, 8'h00);
      chk("mid_reset_edit", {7'd0, edit_y}, 8'h00);
      chk("mid_reset_month", bcd_m, 8'h01);
      reset = 1'b0; cyc(6);
      chk("held_after_reset", bcd_y, 8'h00);
      Arriba = 1'b0; cyc(1);
      Arriba = 1'b1; cyc(1);
      chk("repress", bcd_y, 8'h01);
      Arriba = 1'b0; cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
